// File: rtl/hamming_pkg.sv
// Shared constants and helpers for the SECDED Hamming stream codec:
// parity-count derivation, codeword width and the data-bit <-> position maps.
package hamming_pkg;

    typedef enum logic {
        MODE_ENC = 1'b0,
        MODE_DEC = 1'b1
    } mode_e;

    // Smallest P with 2^P >= DATA_W + P + 1.
    function automatic int calc_p(input int data_w);
        int p;
        p = 1;
        for (int i = 0; i < 8; i++) begin
            if ((1 << p) < data_w + p + 1) begin
                p++;
            end
        end
        return p;
    endfunction

    function automatic int calc_code_w(input int data_w);
        return data_w + calc_p(data_w) + 1;
    endfunction

    function automatic bit is_pow2(input int v);
        return (v > 0) && ((v & (v - 1)) == 0);
    endfunction

    // Codeword position of data bit idx (positions 3,5,6,7,9,...).
    function automatic int data_pos(input int idx);
        int n;
        int pos;
        n   = 0;
        pos = 0;
        for (int p = 3; p < 128; p++) begin
            if (!is_pow2(p)) begin
                if (n == idx && pos == 0) begin
                    pos = p;
                end
                n++;
            end
        end
        return pos;
    endfunction

    // Inverse map: data-bit index carried at a non-parity position.
    function automatic int data_idx(input int pos);
        int n;
        n = 0;
        for (int p = 1; p < pos; p++) begin
            if (!is_pow2(p)) begin
                n++;
            end
        end
        return n;
    endfunction

endpackage

// File: rtl/hamming_syndrome.sv
// Combinational syndrome/parity of a codeword: XOR of the indices of all set
// bits in positions 1..CODE_W-1, and the XOR of every bit.
module hamming_syndrome
    import hamming_pkg::*;
#(
    parameter int DATA_W = 4,
    localparam int P      = calc_p(DATA_W),
    localparam int CODE_W = calc_code_w(DATA_W)
) (
    input  logic [CODE_W-1:0] code_i,
    output logic [P-1:0]      syndrome_o,
    output logic              parity_o
);

    logic [P-1:0] term [CODE_W];

    generate
        for (genvar gi = 0; gi < CODE_W; gi++) begin : g_term
            if (gi == 0) begin : g_zero
                assign term[gi] = '0;
            end else begin : g_idx
                assign term[gi] = code_i[gi] ? P'(gi) : '0;
            end
        end
    endgenerate

    always_comb begin
        syndrome_o = '0;
        for (int i = 0; i < CODE_W; i++) begin
            syndrome_o = syndrome_o ^ term[i];
        end
    end

    assign parity_o = ^code_i;

endmodule

// File: rtl/hamming_secded_stream.sv
// Two-stage streaming SECDED encoder/decoder with per-beat mode, valid/ready
// flow control and saturating error counters.
module hamming_secded_stream
    import hamming_pkg::*;
#(
    parameter int DATA_W = 4,
    localparam int P      = calc_p(DATA_W),
    localparam int CODE_W = calc_code_w(DATA_W)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_mode,
    input  logic [CODE_W-1:0] in_word,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CODE_W-1:0] out_word,
    output logic              out_mode,
    output logic              out_err_single,
    output logic              out_err_double,
    output logic [P-1:0]      out_syndrome,
    input  logic              clr_cnt,
    output logic [15:0]       cnt_corrected,
    output logic [15:0]       cnt_uncorrectable
);

    localparam logic [P:0] LAST_POS = (P+1)'(CODE_W - 1);

    logic en;

    // Stage 1 signals
    logic [CODE_W-1:0] scatter_word;
    logic [CODE_W-1:0] s1_word_d, s1_word_q;
    logic [P-1:0]      s1_syn_d, s1_syn_q;
    logic              s1_par_d, s1_par_q;
    logic              s1_valid_q;
    mode_e             s1_mode_q;

    // Stage 2 signals
    logic [CODE_W-1:0] enc_code;
    logic [CODE_W-1:0] flip_mask, corrected;
    logic [DATA_W-1:0] dec_data;
    logic              syn_in_range, dec_single, dec_double;
    logic [CODE_W-1:0] out_word_d, out_word_q;
    logic [P-1:0]      out_syn_d, out_syn_q;
    logic              out_single_d, out_single_q;
    logic              out_double_d, out_double_q;
    mode_e             out_mode_d, out_mode_q;
    logic              out_valid_q;

    logic [15:0] cnt_corr_d, cnt_corr_q;
    logic [15:0] cnt_unc_d, cnt_unc_q;
    logic        delivered;

    assign en       = !out_valid_q || out_ready;
    assign in_ready = en;

    // Encode beats run the syndrome unit over data placed at its positions
    // with zeroed parity slots, which yields the Hamming parity bits directly.
    generate
        for (genvar gi = 0; gi < CODE_W; gi++) begin : g_scatter
            if (gi == 0 || is_pow2(gi)) begin : g_par
                assign scatter_word[gi] = 1'b0;
            end else begin : g_dat
                assign scatter_word[gi] = in_word[data_idx(gi)];
            end
        end
    endgenerate

    assign s1_word_d = (mode_e'(in_mode) == MODE_DEC) ? in_word : scatter_word;

    hamming_syndrome #(.DATA_W(DATA_W)) u_syndrome (
        .code_i    (s1_word_d),
        .syndrome_o(s1_syn_d),
        .parity_o  (s1_par_d)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_mode_q  <= MODE_ENC;
            s1_word_q  <= '0;
            s1_syn_q   <= '0;
            s1_par_q   <= 1'b0;
        end else if (en) begin
            s1_valid_q <= in_valid;
            s1_mode_q  <= mode_e'(in_mode);
            s1_word_q  <= s1_word_d;
            s1_syn_q   <= s1_syn_d;
            s1_par_q   <= s1_par_d;
        end
    end

    // Overall parity of an encoded word = data parity ^ Hamming parity bits.
    generate
        for (genvar gi = 0; gi < CODE_W; gi++) begin : g_enc
            if (gi == 0) begin : g_all
                assign enc_code[gi] = s1_par_q ^ (^s1_syn_q);
            end else if (is_pow2(gi)) begin : g_ham
                assign enc_code[gi] = s1_syn_q[$clog2(gi)];
            end else begin : g_dat
                assign enc_code[gi] = s1_word_q[gi];
            end
        end
    endgenerate

    assign syn_in_range = ({1'b0, s1_syn_q} <= LAST_POS);
    assign dec_single   = s1_par_q && syn_in_range;
    assign dec_double   = s1_par_q ? !syn_in_range : (s1_syn_q != '0);
    assign flip_mask    = dec_single ? (CODE_W'(1) << s1_syn_q) : '0;
    assign corrected    = s1_word_q ^ flip_mask;

    generate
        for (genvar gi = 0; gi < DATA_W; gi++) begin : g_extract
            assign dec_data[gi] = corrected[data_pos(gi)];
        end
    endgenerate

    always_comb begin
        out_word_d   = enc_code;
        out_syn_d    = '0;
        out_single_d = 1'b0;
        out_double_d = 1'b0;
        out_mode_d   = s1_mode_q;
        if (s1_mode_q == MODE_DEC) begin
            out_word_d   = {{(CODE_W-DATA_W){1'b0}}, dec_data};
            out_syn_d    = s1_syn_q;
            out_single_d = dec_single;
            out_double_d = dec_double;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q  <= 1'b0;
            out_word_q   <= '0;
            out_mode_q   <= MODE_ENC;
            out_single_q <= 1'b0;
            out_double_q <= 1'b0;
            out_syn_q    <= '0;
        end else if (en) begin
            out_valid_q  <= s1_valid_q;
            out_word_q   <= out_word_d;
            out_mode_q   <= out_mode_d;
            out_single_q <= out_single_d;
            out_double_q <= out_double_d;
            out_syn_q    <= out_syn_d;
        end
    end

    assign delivered = out_valid_q && out_ready && (out_mode_q == MODE_DEC);

    always_comb begin
        cnt_corr_d = cnt_corr_q;
        cnt_unc_d  = cnt_unc_q;
        if (clr_cnt) begin
            cnt_corr_d = '0;
            cnt_unc_d  = '0;
        end else begin
            if (delivered && out_single_q && cnt_corr_q != 16'hFFFF) begin
                cnt_corr_d = cnt_corr_q + 16'd1;
            end
            if (delivered && out_double_q && cnt_unc_q != 16'hFFFF) begin
                cnt_unc_d = cnt_unc_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_corr_q <= '0;
            cnt_unc_q  <= '0;
        end else begin
            cnt_corr_q <= cnt_corr_d;
            cnt_unc_q  <= cnt_unc_d;
        end
    end

    assign out_valid         = out_valid_q;
    assign out_word          = out_word_q;
    assign out_mode          = out_mode_q;
    assign out_err_single    = out_single_q;
    assign out_err_double    = out_double_q;
    assign out_syndrome      = out_syn_q;
    assign cnt_corrected     = cnt_corr_q;
    assign cnt_uncorrectable = cnt_unc_q;

endmodule

// File: doc/hamming_secded_stream.md
HAMMING_SECDED_STREAM -- requirements
Module: hamming_secded_stream

Interface
REQ-001 Parameter DATA_W, default 4, data bits per word; legal range 4..57.
REQ-002 Derived constant P: the smallest P with 2^P >= DATA_W+P+1 (3 for DATA_W=4).
REQ-003 Derived constant CODE_W = DATA_W+P+1 (8 for DATA_W=4).
REQ-004 clk  in  1  single clock; all state on rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-high.
REQ-006 in_valid  in  1  input beat valid.
REQ-007 in_ready  out  1  block accepts a beat this cycle.
REQ-008 in_mode  in  1  per-beat mode: 0 = encode, 1 = decode.
REQ-009 in_word  in  CODE_W  encode: data in bits [DATA_W-1:0], upper bits ignored; decode: received codeword.
REQ-010 out_valid  out  1  output beat valid.
REQ-011 out_ready  in  1  downstream accepts the output beat.
REQ-012 out_word  out  CODE_W  encode: codeword; decode: corrected data, zero-extended.
REQ-013 out_mode  out  1  mode of the current output beat.
REQ-014 out_err_single  out  1  decode beat had a corrected single-bit error.
REQ-015 out_err_double  out  1  decode beat had an uncorrectable error.
REQ-016 out_syndrome  out  P  Hamming syndrome of the decode beat; 0 for encode beats.
REQ-017 clr_cnt  in  1  synchronous clear of both error counters.
REQ-018 cnt_corrected  out  16  saturating count of delivered single-error beats.
REQ-019 cnt_uncorrectable  out  16  saturating count of delivered double-error beats.

Function
REQ-020 Codeword layout SHALL be: bit 0 = overall even parity; power-of-two positions 1,2,4,... = Hamming parity; remaining positions 3,5,6,7,... = data bits d0,d1,... in ascending order.
REQ-021 Hamming parity bit at position 2^k SHALL be the XOR of all data positions whose index has bit k set; bit 0 SHALL make the XOR of all CODE_W bits equal 0.
REQ-022 Decode: S = XOR of the indices of all set bits in positions 1..CODE_W-1; Q = XOR of all CODE_W bits.
REQ-023 S=0,Q=0: no error, both flags 0.
REQ-024 Q=1 and S<=CODE_W-1: bit S flipped (S=0 flips bit 0), err_single=1.
REQ-025 Q=0 with S!=0, or Q=1 with S>CODE_W-1: err_double=1; data extracted uncorrected.
REQ-026 Pipeline: two register stages (stage 1: capture + syndrome/parity; stage 2: correct/flag), latency 2 cycles from in handshake to out_valid when unstalled.
REQ-027 Pipeline advance enable en = !out_valid || out_ready; both stages advance together on en; in_ready = en.
REQ-028 A beat transfers on in_valid && in_ready; out_valid holds, and all out_* hold stable, until out_ready.
REQ-029 Bubbles SHALL propagate as invalid; sustained throughput 1 beat/cycle with out_ready high.
REQ-030 Mixed encode/decode beats SHALL be processed in order, each per its own captured mode.
REQ-031 Counters increment once per output handshake of a decode beat with the matching flag; saturate at 16'hFFFF.
REQ-032 clr_cnt takes priority over a same-cycle increment (result 0).

Reset
REQ-033 On rst: both stage valids 0, out_valid 0, out_word 0, out_mode 0, flags 0, out_syndrome 0, counters 0; in_ready SHALL be 1 one cycle after rst deasserts.
REQ-034 rst mid-stream SHALL discard in-flight beats; no partial beat SHALL appear afterward.

Structure
REQ-035 Package hamming_pkg SHALL hold: function calc_p(DATA_W), CODE_W derivation, data-to-position map function, mode enum {MODE_ENC, MODE_DEC}.
REQ-036 One sub-module hamming_syndrome (combinational, parametrised by DATA_W) computes parity/syndrome and is shared by the encode and decode paths.

Verification (DATA_W=4)
REQ-037 Encode in_word=4'hB -> out_word=8'hAA two cycles later, flags 0, syndrome 0.
REQ-038 Decode 8'hAA -> out_word=0x0B, no flags; decode 8'h8A (bit 5 flipped) -> 0x0B, err_single=1, syndrome=5, cnt_corrected=1.
REQ-039 Decode 8'h82 (bits 3,5 flipped) -> out_word=0x08, err_double=1, syndrome=6, cnt_uncorrectable=1; decode 8'hAB -> 0x0B, err_single=1, syndrome=0.
REQ-040 Back-to-back 8 beats with out_ready toggling every other cycle -> all 8 outputs delivered in order, none dropped or duplicated, outputs stable while stalled.
REQ-041 Counter preloaded to 16'hFFFF plus one more error -> holds 16'hFFFF; clr_cnt with same-cycle error -> 0.
REQ-042 rst asserted with 2 beats in flight -> out_valid 0 immediately, no stale beat emitted after release.
